// File: rtl/led_switch_panel.sv
// Board-level LED/switch controller: debounced switches pick an off/count/chase/mirror
// pattern advanced by a prescaled tick. Optional PWM dimming is enabled by LED_PWM_EN.
module led_switch_panel #(
   parameter int NUM_LEDS        = 7,
   parameter int NUM_SWITCHES    = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int TICK_DIV        = 1048576
) (
   input  logic                    SYSTEMCLOCK,
   input  logic                    PUSH_BUTTON_RESET_RAW,
   input  logic [NUM_SWITCHES-1:0] Switch_input,
`ifdef LED_PWM_EN
   input  logic [3:0]              brightness,
`endif
   output logic [NUM_LEDS-1:0]     LED_output,
   output logic [1:0]              mode_out,
   output logic                    tick_out
);

   localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
   localparam int PS_W     = $clog2(TICK_DIV);
   localparam int MIRROR_N = (NUM_LEDS < NUM_SWITCHES) ? NUM_LEDS : NUM_SWITCHES;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_OFF    = 2'b00,
      MODE_COUNT  = 2'b01,
      MODE_CHASE  = 2'b10,
      MODE_MIRROR = 2'b11
   } mode_e;

   function automatic logic [NUM_LEDS-1:0] count_step(input logic [NUM_LEDS-1:0] value,
                                                      input logic down);
      return down ? value - NUM_LEDS'(1) : value + NUM_LEDS'(1);
   endfunction

   function automatic logic [NUM_LEDS-1:0] rotate_one(input logic [NUM_LEDS-1:0] value,
                                                      input logic right);
      return right ? {value[0], value[NUM_LEDS-1:1]}
                   : {value[NUM_LEDS-2:0], value[NUM_LEDS-1]};
   endfunction

   logic                    clk;
   logic [1:0]              rst_sync;
   logic                    rst_n;

   logic [NUM_SWITCHES-1:0] sw_sync_p0;
   logic [NUM_SWITCHES-1:0] sw_sync_p1;
   logic [NUM_SWITCHES-1:0] sw_stable;
   logic [DB_W-1:0]         db_cnt [NUM_SWITCHES];

   mode_e                   state;
   mode_e                   next_state;
   logic                    mode_change;
   logic                    pause;
   logic                    reverse;

   logic [PS_W-1:0]         presc;
   logic                    wrap;
   logic                    tick;
   logic                    advance;

   logic [NUM_LEDS-1:0]     count;
   logic [NUM_LEDS-1:0]     chaser;
   logic [NUM_LEDS-1:0]     mirror;
   logic [NUM_LEDS-1:0]     pattern;
   logic [NUM_LEDS-1:0]     led_drive;

   assign clk = SYSTEMCLOCK;

   // Reset assertion is immediate; release is retimed so all logic leaves reset on one edge.
   always_ff @(posedge clk or negedge PUSH_BUTTON_RESET_RAW) begin
      if (!PUSH_BUTTON_RESET_RAW) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   // Stage p0/p1: metastability synchroniser on the raw pads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_sync_p0 <= '0;
         sw_sync_p1 <= '0;
      end else begin
         sw_sync_p0 <= Switch_input;
         sw_sync_p1 <= sw_sync_p0;
      end
   end

   // A switch is accepted only after it disagrees with the stable value for DEBOUNCE_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_stable <= '0;
         for (int i = 0; i < NUM_SWITCHES; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SWITCHES; i++) begin
            if (sw_sync_p1[i] == sw_stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               sw_stable[i] <= sw_sync_p1[i];
               db_cnt[i]    <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign pause   = sw_stable[2];
   assign reverse = sw_stable[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MODE_OFF;
      end else begin
         state <= next_state;
      end
   end

   assign wrap = (presc == PS_LAST);
   assign tick = wrap & ~pause;

   always_comb begin
      mirror                 = '0;
      mirror[MIRROR_N-1:0]   = sw_stable[MIRROR_N-1:0];
   end

   // A tick landing on the mode-change cycle is dropped so the restart value is what shows.
   always_comb begin
      next_state  = mode_e'(sw_stable[1:0]);
      mode_change = (next_state != state);
      advance     = 1'b0;
      pattern     = '0;
      case (state)
         MODE_COUNT: begin
            advance = tick & ~mode_change;
            pattern = count;
         end
         MODE_CHASE: begin
            advance = tick & ~mode_change;
            pattern = chaser;
         end
         MODE_MIRROR: begin
            pattern = mirror;
         end
         default: begin
            pattern = '0;
         end
      endcase
   end

   assign mode_out = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (mode_change || wrap) begin
         presc <= '0;
      end else begin
         presc <= presc + PS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         chaser <= NUM_LEDS'(1);
      end else if (mode_change) begin
         count  <= '0;
         chaser <= NUM_LEDS'(1);
      end else if (advance) begin
         if (state == MODE_COUNT) begin
            count <= count_step(count, reverse);
         end
         if (state == MODE_CHASE) begin
            chaser <= rotate_one(chaser, reverse);
         end
      end
   end

`ifdef LED_PWM_EN
   logic [3:0] pwm_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= 4'd0;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
      end
   end

   assign led_drive = pattern & {NUM_LEDS{pwm_cnt < brightness}};
`else
   assign led_drive = pattern;
`endif

   // Output stage: registered LED drive and tick pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LED_output <= '0;
         tick_out   <= 1'b0;
      end else begin
         LED_output <= led_drive;
         tick_out   <= advance;
      end
   end

endmodule

// File: tb/tb_led_switch_panel.sv
// Directed bench for led_switch_panel with a short debounce and tick period.
module tb_led_switch_panel;

   localparam int NL = 7;
   localparam int NS = 4;
   localparam int DB = 4;
   localparam int TD = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NS-1:0] sw;
   logic [NL-1:0] led;
   logic [1:0]    mode;
   logic          tick;
`ifdef LED_PWM_EN
   logic [3:0]    brightness;
`endif

   always #5 clk = ~clk;

   led_switch_panel #(
      .NUM_LEDS(NL),
      .NUM_SWITCHES(NS),
      .DEBOUNCE_CYCLES(DB),
      .TICK_DIV(TD)
   ) dut (
      .SYSTEMCLOCK(clk),
      .PUSH_BUTTON_RESET_RAW(rst_n),
      .Switch_input(sw),
`ifdef LED_PWM_EN
      .brightness(brightness),
`endif
      .LED_output(led),
      .mode_out(mode),
      .tick_out(tick)
   );

   typedef struct {
      logic [NS-1:0] sw;
      int            ticks;
      logic [NL-1:0] led;
      logic [1:0]    mode;
   } vec_t;

   vec_t vecs [13];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns one cycle after tick_out is seen, when LED_output shows the advanced pattern.
   task automatic wait_tick();
      int   n    = 0;
      logic seen = 1'b0;
      while (!seen && n < 4 * TD) begin
         cyc(1);
         n++;
         if (tick === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL wait_tick timeout after %0d cycles at %0t", n, $time);
      end
      cyc(1);
   endtask

   initial begin
      int pulses;
      int lit;
      int bad;

      vecs[0]  = '{sw: 4'b1001, ticks: 1, led: 7'd1,        mode: 2'd1};
      vecs[1]  = '{sw: 4'b1001, ticks: 1, led: 7'd0,        mode: 2'd1};
      vecs[2]  = '{sw: 4'b1001, ticks: 1, led: 7'd127,      mode: 2'd1};
      vecs[3]  = '{sw: 4'b1001, ticks: 1, led: 7'd126,      mode: 2'd1};
      vecs[4]  = '{sw: 4'b0010, ticks: 0, led: 7'b0000001,  mode: 2'd2};
      vecs[5]  = '{sw: 4'b0010, ticks: 1, led: 7'b0000010,  mode: 2'd2};
      vecs[6]  = '{sw: 4'b0010, ticks: 5, led: 7'b1000000,  mode: 2'd2};
      vecs[7]  = '{sw: 4'b0010, ticks: 1, led: 7'b0000001,  mode: 2'd2};
      vecs[8]  = '{sw: 4'b1010, ticks: 1, led: 7'b1000000,  mode: 2'd2};
      vecs[9]  = '{sw: 4'b1010, ticks: 1, led: 7'b0100000,  mode: 2'd2};
      vecs[10] = '{sw: 4'b0011, ticks: 0, led: 7'b0000011,  mode: 2'd3};
      vecs[11] = '{sw: 4'b1111, ticks: 0, led: 7'b0001111,  mode: 2'd3};
      vecs[12] = '{sw: 4'b0000, ticks: 0, led: 7'b0000000,  mode: 2'd0};

      rst_n = 1'b0;
      sw    = '0;
`ifdef LED_PWM_EN
      brightness = 4'd15;
`endif
      cyc(3);
      check("rst_led", 32'(led), 32'd0);
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);

      rst_n  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3 * TD; i++) begin
         cyc(1);
         if (tick === 1'b1) pulses++;
      end
      check("idle_tick_pulses", 32'(pulses), 32'd0);
      check("idle_led", 32'(led), 32'd0);
      check("idle_mode", 32'(mode), 32'd0);

      sw = 4'b0001;
      cyc(3);
      sw = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         check("glitch_mode", 32'(mode), 32'd0);
      end

      sw = 4'b0001;
      for (int k = 1; k <= 7; k++) begin
         cyc(1);
         check($sformatf("db_mode_edge%0d", k), 32'(mode), (k >= 7) ? 32'd1 : 32'd0);
      end

      for (int i = 1; i <= 130; i++) begin
         wait_tick();
         check($sformatf("count_up_%0d", i), 32'(led), 32'(i % 128));
      end

      for (int v = 0; v < 13; v++) begin
         sw = vecs[v].sw;
         if (vecs[v].ticks == 0) begin
            cyc(8);
         end else begin
            repeat (vecs[v].ticks) wait_tick();
         end
         check($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].led));
         check($sformatf("vec%0d_mode", v), 32'(mode), 32'(vecs[v].mode));
      end

      sw = 4'b0001;
      cyc(8);
      check("pause_entry_mode", 32'(mode), 32'd1);
      repeat (3) wait_tick();
      check("pause_pre_led", 32'(led), 32'd3);
      sw     = 4'b0101;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (tick === 1'b1) pulses++;
      end
      check("pause_tick_pulses", 32'(pulses), 32'd0);
      check("pause_led", 32'(led), 32'd3);
      sw = 4'b0001;
      wait_tick();
      check("unpause_led", 32'(led), 32'd4);

      repeat (33) wait_tick();
      check("mid_count_led", 32'(led), 32'h25);
      sw = 4'b0010;
      cyc(7);
      check("to_chase_mode", 32'(mode), 32'd2);
      check("to_chase_tick_dropped", 32'(tick), 32'd0);
      cyc(1);
      check("to_chase_led", 32'(led), 32'b0000001);
      sw = 4'b0001;
      cyc(7);
      check("to_count_mode", 32'(mode), 32'd1);
      check("to_count_tick_dropped", 32'(tick), 32'd0);
      cyc(1);
      check("to_count_led", 32'(led), 32'd0);
      wait_tick();
      check("count_restart_led", 32'(led), 32'd1);

      rst_n = 1'b0;
      #1;
      check("async_rst_led", 32'(led), 32'd0);
      check("async_rst_mode", 32'(mode), 32'd0);
      check("async_rst_tick", 32'(tick), 32'd0);
      sw = 4'b0000;
      cyc(2);
      rst_n = 1'b1;
      cyc(4);
      check("post_rst_led", 32'(led), 32'd0);
      check("post_rst_mode", 32'(mode), 32'd0);

`ifdef LED_PWM_EN
      sw         = 4'b1111;
      brightness = 4'd4;
      cyc(10);
      lit = 0;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         cyc(1);
         if (led === 7'b0001111) lit++;
         else if (led !== 7'b0000000) bad++;
      end
      check("pwm4_lit_cycles", 32'(lit), 32'd8);
      check("pwm4_bad_cycles", 32'(bad), 32'd0);
      brightness = 4'd0;
      cyc(2);
      lit = 0;
      for (int i = 0; i < 32; i++) begin
         cyc(1);
         if (led !== 7'b0000000) lit++;
      end
      check("pwm0_lit_cycles", 32'(lit), 32'd0);
`else
      lit = 0;
      bad = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_switch_panel.md
Name: led_switch_panel

Overview:
- Parametrised board-level LED/switch controller; generalises the fixed 7-LED/4-switch top level.
- Debounces NUM_SWITCHES raw switches and decodes a display mode from them.
- Drives NUM_LEDS outputs with an off, counter, chaser or switch-mirror pattern, advanced by a prescaled tick.
- Instantiated directly under the board top level, between pads and LEDs.

Parameters:
- NUM_LEDS, 7, LED output count; legal range 2..32.
- NUM_SWITCHES, 4, switch input count; legal range 4..16.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a switch change; must be >= 2.
- TICK_DIV, 1048576, SYSTEMCLOCK cycles per pattern tick; must be >= 2.

Ports:
- SYSTEMCLOCK  input  1  sole clock, all logic on rising edge.
- PUSH_BUTTON_RESET_RAW  input  1  reset, asynchronous, active-low.
- Switch_input  input  NUM_SWITCHES  raw, asynchronous switch pads.
- LED_output  output  NUM_LEDS  registered LED drive, 1 = lit.
- mode_out  output  2  current decoded mode, registered.
- tick_out  output  1  single-cycle pulse on each pattern advance.

Behaviour:
- Reset
  - Assertion is asynchronous. Release passes through a 2-flop synchroniser, so internal reset deasserts on the 2nd rising edge after the pin goes high.
  - Reset values: LED_output=0, mode_out=0, tick_out=0, all debounced switches=0, debounce counters=0, prescaler=0, count register=0, chaser register=one-hot bit 0.
- Debounce, per switch
  - 2-flop synchroniser, then a counter.
  - If sync == stable: counter clears.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - Acceptance latency is 2 + DEBOUNCE_CYCLES cycles from the pad edge. A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Switch decode (debounced sw)
  - mode = sw[1:0]: 00 OFF, 01 COUNT, 10 CHASE, 11 MIRROR.
  - pause = sw[2].
  - reverse = sw[3].
  - Remaining switches are used only by MIRROR.
- Prescaler
  - Counts 0..TICK_DIV-1 and wraps; runs regardless of pause.
  - tick = wrap AND NOT pause. tick_out is registered, one cycle after the wrap.
- Mode state machine: OFF/COUNT/CHASE/MIRROR follow the debounced mode directly. On any mode change, in the same cycle that mode_out updates:
  - count register <= 0
  - chaser <= one-hot bit 0
  - prescaler <= 0
- OFF: pattern all zeros.
- COUNT
  - On tick, count +1 (reverse=0) or -1 (reverse=1), modulo 2^NUM_LEDS.
  - Wraps all-ones -> 0 and 0 -> all-ones.
- CHASE
  - On tick, rotate left (reverse=0) or right (reverse=1).
  - MSB -> bit 0 and bit 0 -> MSB wrap. Exactly one bit set at all times.
- MIRROR
  - pattern[i] = sw[i] for i < min(NUM_LEDS, NUM_SWITCHES); remaining bits 0.
  - Ignores tick, pause and reverse.
- Output timing
  - LED_output <= pattern, one cycle after the pattern register or switch update.
  - A tick coincident with a mode change is discarded; the reset-on-change wins.
- Reset mid-pattern returns all state to the reset values; no partial update survives.

Optional Feature:
- Macro LED_PWM_EN.
- When defined:
  - Adds input brightness [3:0].
  - A free-running 4-bit pwm_cnt increments every cycle and resets to 0.
  - LED_output = registered(pattern AND replicate(pwm_cnt < brightness)).
  - brightness 0 = always dark; brightness 15 = lit 15 of every 16 cycles. Period is 16 cycles.
- When undefined: the brightness port and pwm_cnt do not exist, and LED_output = registered pattern.

Test Plan (NUM_LEDS=7, NUM_SWITCHES=4, DEBOUNCE_CYCLES=4, TICK_DIV=8):
- Reset: hold reset low, then release with Switch_input=0000 -> LED_output=0, mode_out=0, tick_out never pulses.
- Debounce: 3-cycle pulse on Switch_input[0] -> no mode change. A level held >= 6 cycles -> mode_out=01 exactly 2+4 cycles after the edge, plus 1 register stage.
- COUNT: COUNT with reverse=0, run 130 ticks -> LED_output steps 0,1,2...127,0,1,2. Set reverse=1 -> next tick decrements 2->1. Set pause=1 -> value frozen, tick_out stays 0.
- CHASE: CHASE with reverse=0 -> 0000001, 0000010 ... 1000000, 0000001 on successive ticks. With reverse=1 from 0000001 -> 1000000.
- Mode change mid-count at count=0x25: COUNT->CHASE->COUNT -> chaser restarts at 0000001, then count restarts at 0. A tick on the switching cycle is ignored.
- MIRROR plus PWM (build with LED_PWM_EN): Switch_input=1111, brightness=4 -> LED_output = 0001111 for 4 of every 16 cycles and 0000000 otherwise. brightness=0 -> always 0.
